// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Load/store unit between the EX/MEM register and a word-wide
//               data memory. Sub-word stores are merged read-modify-write.
//               Optional alignment checking: define MEM_MISALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        misalign_q, misalign_d;

  logic        req_misaligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:12];

`ifdef MEM_MISALIGN_CHK_EN
  assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  // Halfword lane selection deliberately ignores addr[0].
  assign lane_b = dm_dout[{req_addr[1:0], 3'b000} +: 8];
  assign lane_h = dm_dout[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (req_size)
      2'b00:   load_ext = {{24{~req_unsigned & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~req_unsigned & lane_h[15]}}, lane_h};
      default: load_ext = dm_dout;
    endcase
  end

  always_comb begin
    merged = rdata_q;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    misalign_d = 1'b0;
    dm_addr    = req_addr[11:2];
    dm_din     = req_wdata;
    dm_we      = 1'b0;
    stall      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_misaligned) begin
          misalign_d = 1'b1;
        end else if (req_valid && req_we) begin
          if (req_size[1]) begin
            dm_we = 1'b1;
          end else begin
            addr_d  = req_addr[11:0];
            size_d  = req_size;
            wdata_d = req_wdata[15:0];
            rdata_d = dm_dout;
            stall   = 1'b1;
            state_d = S_WRITE;
          end
        end else if (req_valid) begin
          ld_valid_d = 1'b1;
          ld_data_d  = load_ext;
        end
      end
      // Request inputs here are the held copy of the store being finished.
      S_WRITE: begin
        dm_addr = addr_q[11:2];
        dm_din  = merged;
        dm_we   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      dm_we = 1'b0;
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign misalign = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access with a word-wide
//               memory model. Honours MEM_MISALIGN_CHK_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misalign;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .dm_addr     (dm_addr),
    .dm_din      (dm_din),
    .dm_we       (dm_we),
    .dm_dout     (dm_dout),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (dm_we) mem[dm_addr] <= dm_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  initial begin
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rst = 1'b1;
    // A word store held during reset must not reach memory.
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678);
    tick(); tick();
    @(negedge clk);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    tick();
    rst = 1'b0;
    idle();

    // Word store then word load
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wst_dm_we", {31'h0, dm_we}, 32'h1);
    check("wst_stall", {31'h0, stall}, 32'h0);
    check("wst_dm_addr", {22'h0, dm_addr}, 32'h4);
    check("wst_dm_din", dm_din, 32'hDEAD_BEEF);
    tick();
    req(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check("wld_dm_we", {31'h0, dm_we}, 32'h0);
    check("wst_mem", mem[4], 32'hDEAD_BEEF);
    tick();
    idle();
    @(negedge clk);
    check("wld_valid", {31'h0, ld_valid}, 32'h1);
    check("wld_data", ld_data, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    check("idle_ld_valid", {31'h0, ld_valid}, 32'h0);
    check("idle_ld_hold", ld_data, 32'hDEAD_BEEF);
    check("idle_dm_we", {31'h0, dm_we}, 32'h0);

    // Byte store merge
    poke(10'd4, 32'h1122_3344);
    req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AB);
    @(negedge clk);
    check("bst_stall", {31'h0, stall}, 32'h1);
    check("bst_dm_we0", {31'h0, dm_we}, 32'h0);
    tick();
    @(negedge clk);
    check("bst_stall2", {31'h0, stall}, 32'h0);
    check("bst_dm_we1", {31'h0, dm_we}, 32'h1);
    check("bst_dm_addr", {22'h0, dm_addr}, 32'h4);
    check("bst_dm_din", dm_din, 32'h1122_AB44);
    tick();
    idle();
    check("bst_mem", mem[4], 32'h1122_AB44);

    // Sub-word loads, back to back
    poke(10'd0, 32'h8000_F0FF);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0);
    tick();
    req(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0);
    @(negedge clk);
    check("ld_sb0", ld_data, 32'hFFFF_FFFF);
    check("ld_sb0_v", {31'h0, ld_valid}, 32'h1);
    tick();
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0);
    @(negedge clk);
    check("ld_uh2", ld_data, 32'h0000_8000);
    tick();
    req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
    @(negedge clk);
    check("ld_sh2", ld_data, 32'hFFFF_8000);
    tick();
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0);
    @(negedge clk);
    check("ld_w11", ld_data, 32'h8000_F0FF);
    tick();
    idle();
    @(negedge clk);
    check("ld_ub1", ld_data, 32'h0000_00F0);

    // Halfword store to 0x013
    poke(10'd4, 32'h1122_3344);
    req(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_5566);
`ifdef MEM_MISALIGN_CHK_EN
    @(negedge clk);
    check("mis_dm_we", {31'h0, dm_we}, 32'h0);
    check("mis_stall", {31'h0, stall}, 32'h0);
    tick();
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0);
    @(negedge clk);
    check("mis_pulse", {31'h0, misalign}, 32'h1);
    tick();
    idle();
    @(negedge clk);
    check("mis_wld_pulse", {31'h0, misalign}, 32'h1);
    check("mis_wld_valid", {31'h0, ld_valid}, 32'h0);
    tick();
    @(negedge clk);
    check("mis_clear", {31'h0, misalign}, 32'h0);
    check("mis_mem", mem[4], 32'h1122_3344);
`else
    @(negedge clk);
    check("hst_stall", {31'h0, stall}, 32'h1);
    tick();
    @(negedge clk);
    check("hst_dm_we", {31'h0, dm_we}, 32'h1);
    check("hst_dm_din", dm_din, 32'h5566_3344);
    tick();
    idle();
    @(negedge clk);
    check("hst_misalign", {31'h0, misalign}, 32'h0);
    check("hst_mem", mem[4], 32'h5566_3344);
`endif

    // Reset during the merge write cycle
    tick();
    poke(10'd8, 32'hCAFE_F00D);
    req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_0077);
    @(negedge clk);
    check("abort_stall", {31'h0, stall}, 32'h1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_dm_we", {31'h0, dm_we}, 32'h0);
    check("abort_stall2", {31'h0, stall}, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("abort_idle", {31'h0, dm_we}, 32'h0);
    check("abort_ld_valid", {31'h0, ld_valid}, 32'h0);
    check("abort_ld_data", ld_data, 32'h0);
    check("abort_mem", mem[8], 32'hCAFE_F00D);

    // Store then immediate load sees merged word
    tick();
    req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0000_0099);
    tick();
    @(negedge clk);
    check("fwd_dm_din", dm_din, 32'hCAFE_F099);
    tick();
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    req(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_BEEF);
    @(negedge clk);
    check("fwd_ld_data", ld_data, 32'hCAFE_F099);
    check("fwd_ld_valid", {31'h0, ld_valid}, 32'h1);
    check("hi_stall", {31'h0, stall}, 32'h1);
    tick();
    @(negedge clk);
    check("hi_dm_din", dm_din, 32'hBEEF_F099);
    tick();
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("hi_ld_data", ld_data, 32'hFFFF_BEEF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port clk  in  1  rising-edge clock.
REQ-003 Port rst  in  1  synchronous active-high reset.
REQ-004 Port req_valid  in  1  memory request present from EX/MEM register.
REQ-005 Port req_we  in  1  1=store, 0=load.
REQ-006 Port req_size  in  2  00=byte, 01=halfword, 10=word; 11 treated as word.
REQ-007 Port req_unsigned  in  1  1=zero-extend loads, 0=sign-extend.
REQ-008 Port req_addr  in  32  byte address; only bits [11:0] used.
REQ-009 Port req_wdata  in  32  store data, right-justified.
REQ-010 Port stall  out  1  combinational; upstream holds its request while high.
REQ-011 Port dm_addr  out  10  word address to data memory (byte address bits [11:2]).
REQ-012 Port dm_din  out  32  word written to data memory.
REQ-013 Port dm_we  out  1  data memory write enable.
REQ-014 Port dm_dout  in  32  asynchronous read word from data memory at dm_addr.
REQ-015 Port ld_valid  out  1  registered; one-cycle pulse with load result.
REQ-016 Port ld_data  out  32  registered, extended load result.
REQ-017 Port misalign  out  1  registered; one-cycle pulse on misaligned access.

Function
REQ-018 Byte lanes SHALL be little-endian: offset 0 = bits [7:0], offset 3 = bits [31:24]; halfword offset 0 = [15:0], offset 2 = [31:16].
REQ-019 FSM SHALL have two states, IDLE and WRITE.
REQ-020 IDLE, word store: dm_addr=req_addr[11:2], dm_din=req_wdata, dm_we=1, stall=0, stay IDLE.
REQ-021 IDLE, byte/half store: latch addr, size, wdata, dm_dout; stall=1, dm_we=0, next state WRITE.
REQ-022 WRITE: dm_addr=latched addr, dm_din=latched read word with selected lane(s) replaced by latched wdata low bits, dm_we=1, stall=0, next state IDLE.
REQ-023 In WRITE, request inputs SHALL be ignored; they are the held duplicate of the store being completed.
REQ-024 IDLE, load: dm_addr=req_addr[11:2], dm_we=0; next edge ld_data=selected lane extended per req_unsigned, ld_valid=1; latency 1 cycle, no stall.
REQ-025 Word load SHALL return dm_dout unchanged regardless of req_unsigned.
REQ-026 When req_valid=0, dm_we=0, stall=0, ld_valid next cycle 0.
REQ-027 ld_data SHALL hold its value when ld_valid=0.
REQ-028 Store data SHALL be visible to a load issued the cycle after the store's final write cycle.

Reset
REQ-029 While rst=1: dm_we=0, stall=0, and FSM SHALL enter IDLE at the edge.
REQ-030 On reset: ld_data=0, ld_valid=0, misalign=0, latched registers=0.
REQ-031 Reset asserted in WRITE SHALL abort the merge; no memory write occurs.

Configuration
REQ-032 Macro MEM_MISALIGN_CHK_EN SHALL select alignment checking.
REQ-033 Defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL suppress dm_we and ld_valid, give stall=0, and pulse misalign next cycle.
REQ-034 Undefined: misalign tied 0; halfword uses addr[1] only, word ignores addr[1:0].

Verification
REQ-035 Word store 0xDEADBEEF to 0x010, then word load 0x010 -> dm_we 1 cycle, stall 0, ld_data=0xDEADBEEF.
REQ-036 Mem word 0x11223344, byte store 0xAB to 0x011 -> stall 1 cycle, then dm_din=0x1122AB44, dm_we=1.
REQ-037 Mem word 0x8000F0FF, signed byte load 0x000 -> 0xFFFFFFFF; unsigned halfword load 0x002 -> 0x00008000.
REQ-038 Halfword store to 0x013 with MEM_MISALIGN_CHK_EN defined -> no write, misalign=1 one cycle; undefined -> store to [31:16], misalign=0.
REQ-039 rst=1 in the WRITE cycle of a byte store -> dm_we=0, memory unchanged, state IDLE, ld_valid=0.
REQ-040 Byte store to 0x020 followed next cycle by load 0x020 -> load returns merged word.
